// File: rtl/pll_ctrl_if.sv
// rtl/pll_ctrl_if.sv - phase-step request/acknowledge bundle for pll_ctrl
interface pll_ctrl_if;
   logic       ps_req;
   logic [2:0] ps_sel;
   logic       ps_dir;
   logic       ps_ack;
   logic       ps_busy;

   modport master (output ps_req, ps_sel, ps_dir, input ps_ack, ps_busy);
   modport slave  (input ps_req, ps_sel, ps_dir, output ps_ack, ps_busy);
endinterface

// File: rtl/pll_ctrl.sv
// rtl/pll_ctrl.sv - PLLA power-up/lock sequencer with dynamic phase-step arbiter
module pll_ctrl #(
   parameter int RST_CYCLES   = 16,
   parameter int LOCK_TIMEOUT = 50000,
   parameter int LOCK_STABLE  = 256,
   parameter int MAX_RETRIES  = 3,
   parameter int PS_PULSE_W   = 4,
   parameter int PS_GAP       = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable_i,
   input  logic       pll_lock_i,
   output logic       pll_reset_o,
   output logic       pll_pwd_o,
   output logic       ready_o,
   output logic       fail_o,
   output logic [1:0] retry_cnt_o,
   output logic [2:0] pll_pssel_o,
   output logic       pll_psdir_o,
   output logic       pll_pspulse_o,
   pll_ctrl_if.slave  ps
);
   localparam int RST_W = $clog2(RST_CYCLES + 1);
   localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);
   localparam int ST_W  = $clog2(LOCK_STABLE + 1);
   localparam int PS_W  = $clog2(((PS_PULSE_W > PS_GAP) ? PS_PULSE_W : PS_GAP) + 1);

   localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
   localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(LOCK_STABLE - 1);
   localparam logic [PS_W-1:0]  PW_LAST  = PS_W'(PS_PULSE_W - 1);
   localparam logic [PS_W-1:0]  GAP_LAST = PS_W'(PS_GAP - 1);

   typedef enum logic [3:0] {
      S_OFF, S_RST, S_WAIT_LOCK, S_STABLE, S_READY,
      S_PS_SETUP, S_PS_PULSE, S_PS_GAP, S_FAIL
   } state_t;

   state_t            state_q, state_d;
   logic              lock_meta_q, lock_s_q;
   logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic [ST_W-1:0]   stab_cnt_q, stab_cnt_d;
   logic [PS_W-1:0]   ps_cnt_q, ps_cnt_d;
   logic [1:0]        retry_q, retry_d;
   logic [2:0]        pssel_q, pssel_d;
   logic              psdir_q, psdir_d;
   logic              ps_ack_q, ps_ack_d;
   logic              pll_reset_q, pll_reset_d;
   logic              pwd_q, pwd_d;
   logic              ready_q, ready_d;
   logic              fail_q, fail_d;
   logic              busy_q, busy_d;
   logic              pulse_q, pulse_d;
   logic              in_step;

   // Two-flop synchronizer for the asynchronous LOCK pin.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
      end else begin
         lock_meta_q <= pll_lock_i;
         lock_s_q    <= lock_meta_q;
      end
   end

   assign in_step = (state_q == S_PS_SETUP) || (state_q == S_PS_PULSE) || (state_q == S_PS_GAP);

   // Next-state, counters and registered-output values; enable=0 overrides everything.
   always_comb begin
      state_d    = state_q;
      rst_cnt_d  = rst_cnt_q;
      to_cnt_d   = to_cnt_q;
      stab_cnt_d = stab_cnt_q;
      ps_cnt_d   = ps_cnt_q;
      retry_d    = retry_q;
      pssel_d    = pssel_q;
      psdir_d    = psdir_q;
      ps_ack_d   = 1'b0;

      case (state_q)
         S_OFF: begin
            if (enable_i) begin
               state_d = S_RST;
               retry_d = 2'd0;
            end
         end
         S_RST: begin
            if (rst_cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
            else                       rst_cnt_d = rst_cnt_q + 1'b1;
         end
         S_WAIT_LOCK, S_STABLE: begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (!lock_s_q) begin
               state_d = S_WAIT_LOCK;
            end else if (stab_cnt_q == ST_LAST) begin
               state_d = S_READY;
            end else begin
               state_d    = S_STABLE;
               stab_cnt_d = stab_cnt_q + 1'b1;
            end
            // A lock that completes on the timeout cycle is kept rather than retried.
            if (to_cnt_q == TO_LAST && state_d != S_READY) begin
               if (int'(retry_q) < MAX_RETRIES) begin
                  retry_d = retry_q + 2'd1;
                  state_d = S_RST;
               end else begin
                  state_d = S_FAIL;
               end
            end
         end
         S_READY: begin
            if (!lock_s_q) begin
               state_d = S_RST;
               retry_d = 2'd0;
            end else if (ps.ps_req) begin
               pssel_d = ps.ps_sel;
               psdir_d = ps.ps_dir;
               state_d = S_PS_SETUP;
            end
         end
         S_PS_SETUP: state_d = S_PS_PULSE;
         S_PS_PULSE: begin
            if (ps_cnt_q == PW_LAST) begin
               state_d  = S_PS_GAP;
               ps_cnt_d = '0;
            end else begin
               ps_cnt_d = ps_cnt_q + 1'b1;
            end
         end
         S_PS_GAP: begin
            if (ps_cnt_q == GAP_LAST) begin
               state_d  = S_READY;
               ps_ack_d = 1'b1;
            end else begin
               ps_cnt_d = ps_cnt_q + 1'b1;
            end
         end
         S_FAIL:  state_d = S_FAIL;
         default: state_d = S_OFF;
      endcase

      // Lock loss aborts a step without acknowledging it.
      if (in_step && !lock_s_q) begin
         state_d  = S_RST;
         retry_d  = 2'd0;
         ps_ack_d = 1'b0;
      end

      if (!enable_i) begin
         state_d  = S_OFF;
         ps_ack_d = 1'b0;
      end

      // Each counter only lives inside its own state(s); leaving clears it.
      if (state_d != S_RST) rst_cnt_d = '0;
      if (state_d != S_WAIT_LOCK && state_d != S_STABLE) to_cnt_d = '0;
      if (state_d != S_STABLE) stab_cnt_d = '0;
      if (state_d != S_PS_PULSE && state_d != S_PS_GAP) ps_cnt_d = '0;

      pll_reset_d = (state_d == S_OFF) || (state_d == S_RST) || (state_d == S_FAIL);
      pwd_d       = (state_d == S_OFF);
      ready_d     = (state_d == S_READY) || (state_d == S_PS_SETUP) ||
                    (state_d == S_PS_PULSE) || (state_d == S_PS_GAP);
      fail_d      = (state_d == S_FAIL);
      busy_d      = (state_d == S_PS_SETUP) || (state_d == S_PS_PULSE) || (state_d == S_PS_GAP);
      pulse_d     = (state_d == S_PS_PULSE);
   end

   // State, counters and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_OFF;
         rst_cnt_q   <= '0;
         to_cnt_q    <= '0;
         stab_cnt_q  <= '0;
         ps_cnt_q    <= '0;
         retry_q     <= 2'd0;
         pssel_q     <= 3'd0;
         psdir_q     <= 1'b0;
         ps_ack_q    <= 1'b0;
         pll_reset_q <= 1'b1;
         pwd_q       <= 1'b1;
         ready_q     <= 1'b0;
         fail_q      <= 1'b0;
         busy_q      <= 1'b0;
         pulse_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         rst_cnt_q   <= rst_cnt_d;
         to_cnt_q    <= to_cnt_d;
         stab_cnt_q  <= stab_cnt_d;
         ps_cnt_q    <= ps_cnt_d;
         retry_q     <= retry_d;
         pssel_q     <= pssel_d;
         psdir_q     <= psdir_d;
         ps_ack_q    <= ps_ack_d;
         pll_reset_q <= pll_reset_d;
         pwd_q       <= pwd_d;
         ready_q     <= ready_d;
         fail_q      <= fail_d;
         busy_q      <= busy_d;
         pulse_q     <= pulse_d;
      end
   end

   assign pll_reset_o   = pll_reset_q;
   assign pll_pwd_o     = pwd_q;
   assign ready_o       = ready_q;
   assign fail_o        = fail_q;
   assign retry_cnt_o   = retry_q;
   assign pll_pssel_o   = pssel_q;
   assign pll_psdir_o   = psdir_q;
   assign pll_pspulse_o = pulse_q;
   assign ps.ps_ack     = ps_ack_q;
   assign ps.ps_busy    = busy_q;
endmodule

// File: tb/tb_pll_ctrl.sv
// tb/tb_pll_ctrl.sv - scoreboard bench for pll_ctrl: expected output changes vs observed changes
module tb_pll_ctrl;
   localparam int NSIG = 10;
   // signal indices into the expectation tables
   localparam int S_RESET = 0, S_PWD = 1, S_READY = 2, S_FAIL = 3, S_RETRY = 4;
   localparam int S_ACK = 5, S_BUSY = 6, S_PULSE = 7, S_SEL = 8, S_DIR = 9;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       pll_lock;
   logic       pll_reset, pll_pwd, ready, fail, pll_psdir, pll_pspulse;
   logic [1:0] retry_cnt;
   logic [2:0] pll_pssel;
   logic [2:0] sel;
   logic       dir;

   pll_ctrl_if psif ();

   pll_ctrl #(
      .RST_CYCLES(4), .LOCK_TIMEOUT(100), .LOCK_STABLE(8),
      .MAX_RETRIES(2), .PS_PULSE_W(2), .PS_GAP(3)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable_i(enable), .pll_lock_i(pll_lock),
      .pll_reset_o(pll_reset), .pll_pwd_o(pll_pwd), .ready_o(ready), .fail_o(fail),
      .retry_cnt_o(retry_cnt), .pll_pssel_o(pll_pssel), .pll_psdir_o(pll_psdir),
      .pll_pspulse_o(pll_pspulse), .ps(psif)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      int val;
   } ev_t;

   ev_t   evq[NSIG][$];
   int    model[NSIG];
   int    total = 0;
   int    bad = 0;
   string names[NSIG] = '{"pll_reset", "pll_pwd", "ready", "fail", "retry_cnt",
                          "ps_ack", "ps_busy", "pll_pspulse", "pll_pssel", "pll_psdir"};
   int    rst_val[NSIG] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};

   function automatic int sig_val(int i);
      case (i)
         S_RESET: return int'(pll_reset);
         S_PWD:   return int'(pll_pwd);
         S_READY: return int'(ready);
         S_FAIL:  return int'(fail);
         S_RETRY: return int'(retry_cnt);
         S_ACK:   return int'(psif.ps_ack);
         S_BUSY:  return int'(psif.ps_busy);
         S_PULSE: return int'(pll_pspulse);
         S_SEL:   return int'(pll_pssel);
         default: return int'(pll_psdir);
      endcase
   endfunction

   // Record that output s must change to v at edge c (only if it differs from the prediction so far).
   task automatic set_exp(int s, int c, int v);
      ev_t e;
      if (model[s] != v) begin
         e.cyc = c;
         e.val = v;
         evq[s].push_back(e);
         model[s] = v;
      end
   endtask

   task automatic wait_to(int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic chk(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   int c0, lt, t, reps, nsteps, a, r, x, pend;

   initial begin
      rst_n = 1'b0;
      enable = 1'b0;
      pll_lock = 1'b0;
      psif.ps_req = 1'b0;
      psif.ps_sel = 3'd0;
      psif.ps_dir = 1'b0;
      for (int i = 0; i < NSIG; i++) model[i] = rst_val[i];

      fork
         begin : monitor
            int prev[NSIG];
            int cur;
            ev_t e;
            for (int i = 0; i < NSIG; i++) prev[i] = rst_val[i];
            forever begin
               @(negedge clk);
               for (int i = 0; i < NSIG; i++) begin
                  cur = sig_val(i);
                  if (rst_n) begin
                     if (cur != prev[i]) begin
                        total++;
                        if (evq[i].size() == 0) begin
                           bad++;
                           $display("FAIL %s: unexpected change %0d->%0d at cycle %0d",
                                    names[i], prev[i], cur, cyc);
                        end else begin
                           e = evq[i].pop_front();
                           if (e.cyc != cyc || e.val != cur) begin
                              bad++;
                              $display("FAIL %s: changed to %0d at cycle %0d, expected %0d at cycle %0d",
                                       names[i], cur, cyc, e.val, e.cyc);
                           end
                        end
                     end else if (evq[i].size() > 0 && evq[i][0].cyc <= cyc) begin
                        e = evq[i].pop_front();
                        total++;
                        bad++;
                        $display("FAIL %s: still %0d at cycle %0d, expected %0d at cycle %0d",
                                 names[i], cur, cyc, e.val, e.cyc);
                     end
                  end
                  prev[i] = cur;
               end
            end
         end
      join_none

      // Reset values while rst_n is held low.
      wait_to(2);
      for (int i = 0; i < NSIG; i++) chk({"reset_", names[i]}, sig_val(i), rst_val[i]);
      rst_n = 1'b1;
      wait_to(cyc + 3);

      // 1. Bring-up: 4-cycle reset pulse, ready 10 edges after LOCK rises.
      c0 = cyc;
      enable = 1'b1;
      set_exp(S_PWD, c0 + 1, 0);
      set_exp(S_RESET, c0 + 5, 0);
      wait_to(c0 + 15 + $urandom_range(0, 8));
      lt = cyc;
      pll_lock = 1'b1;
      set_exp(S_READY, lt + 10, 1);
      wait_to(lt + 14);

      // 2. Timeout / retry / fail with LOCK stuck low.
      c0 = cyc;
      enable = 1'b0;
      pll_lock = 1'b0;
      set_exp(S_PWD, c0 + 1, 1);
      set_exp(S_RESET, c0 + 1, 1);
      set_exp(S_READY, c0 + 1, 0);
      wait_to(c0 + 3);
      c0 = cyc;
      enable = 1'b1;
      set_exp(S_PWD, c0 + 1, 0);
      set_exp(S_RESET, c0 + 5, 0);
      t = c0 + 5;
      for (int k = 1; k <= 2; k++) begin
         t += 100;
         set_exp(S_RESET, t, 1);
         set_exp(S_RETRY, t, k);
         t += 4;
         set_exp(S_RESET, t, 0);
      end
      t += 100;
      set_exp(S_FAIL, t, 1);
      set_exp(S_RESET, t, 1);
      wait_to(t + 2);
      psif.ps_req = 1'b1;            // must be ignored outside READY
      wait_to(t + 6);
      psif.ps_req = 1'b0;
      c0 = cyc;
      enable = 1'b0;
      set_exp(S_FAIL, c0 + 1, 0);
      set_exp(S_PWD, c0 + 1, 1);
      wait_to(c0 + 3);

      // 3. Unstable lock: 5 high / 1 low bursts, then steady.
      c0 = cyc;
      enable = 1'b1;
      set_exp(S_PWD, c0 + 1, 0);
      set_exp(S_RETRY, c0 + 1, 0);
      set_exp(S_RESET, c0 + 5, 0);
      wait_to(c0 + 8);
      reps = $urandom_range(2, 4);
      for (int k = 0; k < reps; k++) begin
         pll_lock = 1'b1;
         wait_to(cyc + 5);
         pll_lock = 1'b0;
         wait_to(cyc + 1);
      end
      pll_lock = 1'b1;
      lt = cyc;
      set_exp(S_READY, lt + 10, 1);
      wait_to(lt + 13);

      // 4. Phase steps: random channel/direction, first pair back-to-back.
      nsteps = $urandom_range(3, 5);
      for (int i = 0; i < nsteps; i++) begin
         sel = 3'($urandom_range(0, 7));
         dir = 1'($urandom_range(0, 1));
         psif.ps_req = 1'b1;
         psif.ps_sel = sel;
         psif.ps_dir = dir;
         a = cyc + 1;
         set_exp(S_BUSY, a, 1);
         set_exp(S_SEL, a, int'(sel));
         set_exp(S_DIR, a, int'(dir));
         set_exp(S_PULSE, a + 1, 1);
         set_exp(S_PULSE, a + 3, 0);
         set_exp(S_ACK, a + 6, 1);
         set_exp(S_BUSY, a + 6, 0);
         set_exp(S_ACK, a + 7, 0);
         wait_to(a + 6);
         if (i == nsteps - 1 || (i > 0 && $urandom_range(0, 1) == 0)) begin
            psif.ps_req = 1'b0;
            wait_to(cyc + $urandom_range(1, 4));
         end
      end

      // 5. Lock loss in the middle of a step: abort, no ack, fresh reset pulse.
      sel = 3'($urandom_range(0, 7));
      dir = 1'($urandom_range(0, 1));
      psif.ps_req = 1'b1;
      psif.ps_sel = sel;
      psif.ps_dir = dir;
      a = cyc + 1;
      set_exp(S_BUSY, a, 1);
      set_exp(S_SEL, a, int'(sel));
      set_exp(S_DIR, a, int'(dir));
      set_exp(S_PULSE, a + 1, 1);
      set_exp(S_PULSE, a + 3, 0);
      set_exp(S_BUSY, a + 4, 0);
      set_exp(S_READY, a + 4, 0);
      set_exp(S_RESET, a + 4, 1);
      set_exp(S_RESET, a + 8, 0);
      wait_to(a + 1);
      pll_lock = 1'b0;
      psif.ps_req = 1'b0;
      wait_to(a + 12);
      pll_lock = 1'b1;
      r = cyc;
      set_exp(S_READY, r + 10, 1);
      wait_to(r + 12);

      // 6. Asynchronous reset while counting stable lock cycles.
      x = cyc;
      pll_lock = 1'b0;
      set_exp(S_READY, x + 3, 0);
      set_exp(S_RESET, x + 3, 1);
      set_exp(S_RESET, x + 7, 0);
      wait_to(x + 8);
      pll_lock = 1'b1;
      wait_to(x + 14);
      #2;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < NSIG; i++) chk({"async_", names[i]}, sig_val(i), rst_val[i]);
      pend = 0;
      for (int i = 0; i < NSIG; i++) pend += evq[i].size();
      chk("pending_before_reset", pend, 0);
      for (int i = 0; i < NSIG; i++) begin
         evq[i].delete();
         model[i] = rst_val[i];
      end
      enable = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      wait_to(cyc + 10);

      for (int i = 0; i < NSIG; i++) chk({"leftover_", names[i]}, evq[i].size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/pll_ctrl.md
Name: pll_ctrl

Overview:
- Sequences the PLLA instance in the clocking wrapper: power-up, reset pulse, lock acquisition with timeout and retry, and lock-loss recovery.
- Arbitrates dynamic phase-shift steps (PSSEL/PSDIR/PSPULSE) through a req/ack handshake, issuing them only while the PLL is locked and stable.
- Runs on the free-running board clock (clkin, 50 MHz), never on a PLL output.

Parameters:
RST_CYCLES, 16, cycles pll_reset is held high per attempt (>=1)
LOCK_TIMEOUT, 50000, cycles allowed from reset release to stable lock per attempt
LOCK_STABLE, 256, consecutive synchronized-lock cycles required before ready
MAX_RETRIES, 3, reset attempts after the first before declaring failure (retry_cnt width 2 => <=3)
PS_PULSE_W, 4, cycles pll_pspulse is held high per step
PS_GAP, 8, cycles of low pspulse after each step before ack

Ports:
clk  in  1  controller clock (free-running clkin)
rst_n  in  1  asynchronous active-low reset
enable  in  1  level; 1 = run PLL, 0 = power down
pll_lock  in  1  PLLA LOCK, asynchronous; 2-flop synchronized internally (lock_s)
pll_reset  out  1  to PLLA RESET
pll_pwd  out  1  to PLLA PLLPWD
ready  out  1  PLL locked and stable
fail  out  1  lock not achieved after all retries
retry_cnt  out  2  retries used in the current acquisition
ps_req  in  1  phase-step request, level, held until ps_ack
ps_sel  in  3  output channel to step, sampled on acceptance
ps_dir  in  1  step direction, sampled on acceptance
ps_ack  out  1  one-cycle pulse, step complete
ps_busy  out  1  step in progress
pll_pssel  out  3  to PLLA PSSEL
pll_psdir  out  1  to PLLA PSDIR
pll_pspulse  out  1  to PLLA PSPULSE

Behaviour:
- All outputs registered. Values during rst_n low: pll_pwd=1, pll_reset=1, ready=0, fail=0, retry_cnt=0, ps_ack=0, ps_busy=0, pll_pssel=0, pll_psdir=0, pll_pspulse=0. State = OFF.
- States: OFF, RST, WAIT_LOCK, STABLE, READY, PS_SETUP, PS_PULSE, PS_GAP, FAIL.
- enable=0 in any state: next state OFF, pwd=1, reset=1, ready=0, fail=0, pspulse=0, no ack. This overrides all other transitions.
- OFF: pwd=1, reset=1. On enable=1: go to RST, pwd=0, retry_cnt=0.
- RST: reset=1 for exactly RST_CYCLES cycles, then WAIT_LOCK with reset=0. The timeout counter clears on RST exit.
- WAIT_LOCK: lock_s=1 goes to STABLE.
- STABLE: counts consecutive lock_s=1 cycles; lock_s=0 returns to WAIT_LOCK and clears the stable count; reaching LOCK_STABLE goes to READY, and ready=1 on that edge.
- Timeout counter runs through WAIT_LOCK and STABLE. At LOCK_TIMEOUT:
  - retry_cnt<MAX_RETRIES: retry_cnt+1, go to RST.
  - otherwise: go to FAIL.
- FAIL: fail=1, reset=1, pwd=0. Exit only via enable=0.
- READY:
  - lock_s=0 has priority: ready=0, retry_cnt=0, go to RST.
  - Otherwise ps_req=1: latch ps_sel/ps_dir into pll_pssel/pll_psdir, set ps_busy=1, go to PS_SETUP.
- PS_SETUP: 1 cycle, pspulse=0 (setup time for sel/dir).
- PS_PULSE: pspulse=1 for PS_PULSE_W cycles.
- PS_GAP: pspulse=0 for PS_GAP cycles. Then ps_ack=1 for one cycle, ps_busy=0, return to READY.
- Request acceptance: the earliest next request is accepted the cycle after ps_ack. Total step latency from acceptance = 1+PS_PULSE_W+PS_GAP cycles to ack.
- pll_pssel/pll_psdir hold their last value outside steps.
- ps_req is ignored in every state except READY.
- Lock loss (lock_s=0) during PS_*: abort the step. Next cycle pspulse=0, ps_busy=0, ready=0, no ps_ack, go to RST with retry_cnt=0.
- Lock glitch shorter than 1 cycle may be missed by the synchronizer; this is acceptable.
- Counters are sized by $clog2 of their parameter; no wrap is reachable.

Test Plan:
Parameters for all scenarios: RST_CYCLES=4, LOCK_TIMEOUT=100, LOCK_STABLE=8, MAX_RETRIES=2, PS_PULSE_W=2, PS_GAP=3.
1. Bring-up: rst_n release, enable=1, pll_lock rises 20 cycles after reset release and stays high -> pwd=0, pll_reset high exactly 4 cycles, ready rises exactly 2+8 cycles after pll_lock rises, retry_cnt=0.
2. Timeout/fail: pll_lock held 0 -> three pll_reset pulses of 4 cycles, each 100 cycles apart; retry_cnt steps 1 then 2; fail=1 after the third timeout; enable=0 -> fail=0, pwd=1.
3. Unstable lock: lock toggles high 5 cycles / low 1 cycle, then stays high -> ready stays 0 until 8 consecutive high cycles.
4. Phase step: in READY, ps_req=1, ps_sel=3'd2, ps_dir=1 -> pssel=2, psdir=1; pspulse high 2 cycles starting 1 cycle after acceptance; ps_ack at acceptance+6; back-to-back request accepted the cycle after ack.
5. Lock loss mid-step: drop pll_lock during PS_PULSE -> pspulse=0 and ready=0 within 3 cycles, no ps_ack, new reset pulse of 4 cycles, retry_cnt=0.
6. Async reset mid-acquisition: rst_n low during STABLE -> all outputs at reset values immediately, without waiting for a clock edge.
